// File: rtl/decimating_sample_sync.sv
// decimating_sample_sync
// Multi-channel sample rate reducer: gathers 2^n valid samples per channel and
// emits one reduced sample per channel (last, mean, peak-max or peak-min) to a
// valid/ready consumer. Single clock domain, synchronous active-high reset.
module decimating_sample_sync #(
    parameter int WIDTH        = 12,
    parameter int CHANNELS     = 2,
    parameter int DEC_LOG2_MAX = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    input  logic [CHANNELS*WIDTH-1:0]           in_data,
    input  logic [1:0]                          mode,
    input  logic [$clog2(DEC_LOG2_MAX+1)-1:0]   dec_log2,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CHANNELS*WIDTH-1:0]           out_data,
    output logic                                overrun
);

    localparam int NW = $clog2(DEC_LOG2_MAX + 1);
    localparam int CW = $clog2((1 << DEC_LOG2_MAX) + 1);
    localparam int AW = WIDTH + DEC_LOG2_MAX;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    typedef enum logic [1:0] {
        MODE_LAST = 2'd0,
        MODE_MEAN = 2'd1,
        MODE_MAX  = 2'd2,
        MODE_MIN  = 2'd3
    } mode_t;

    // Window tracking and per-window latched configuration
    state_t                      state;
    logic [CW-1:0]               count;
    logic [1:0]                  win_mode;
    logic [NW-1:0]               win_n;
    logic [AW-1:0]               acc      [CHANNELS];

    // Completed-window result waiting one cycle before reaching the output register
    logic                        res_pend;
    logic [CHANNELS*WIDTH-1:0]   res_data;

    // Combinational next-state values
    logic                        first;
    logic [NW-1:0]               dec_clamped;
    logic [1:0]                  eff_mode;
    logic [NW-1:0]               eff_n;
    logic [CW-1:0]               count_inc;
    logic [CW-1:0]               window_len;
    logic                        window_done;
    logic [AW-1:0]               acc_next [CHANNELS];
    logic [CHANNELS*WIDTH-1:0]   result;

    // Pick the configuration for this sample: live inputs open a window, latched values continue one
    always_comb begin
        dec_clamped = (dec_log2 > NW'(DEC_LOG2_MAX)) ? NW'(DEC_LOG2_MAX) : dec_log2;
        first       = (state == IDLE);
        eff_mode    = first ? mode : win_mode;
        eff_n       = first ? dec_clamped : win_n;
        count_inc   = count + 1'b1;
        window_len  = CW'(1) << eff_n;
        window_done = in_valid && (count_inc == window_len);
    end

    // Per-channel reduction of the incoming sample into the accumulator and the window result
    always_comb begin
        result = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            logic [AW-1:0] sample_ext;
            sample_ext  = AW'(in_data[c*WIDTH +: WIDTH]);
            acc_next[c] = sample_ext;
            case (mode_t'(eff_mode))
                MODE_MEAN: begin
                    if (!first) begin
                        acc_next[c] = acc[c] + sample_ext;
                    end
                end
                MODE_MAX: begin
                    if (!first && (acc[c] > sample_ext)) begin
                        acc_next[c] = acc[c];
                    end
                end
                MODE_MIN: begin
                    if (!first && (acc[c] < sample_ext)) begin
                        acc_next[c] = acc[c];
                    end
                end
                default: begin
                    acc_next[c] = sample_ext;
                end
            endcase
            if (mode_t'(eff_mode) == MODE_MEAN) begin
                result[c*WIDTH +: WIDTH] = WIDTH'(acc_next[c] >> eff_n);
            end else begin
                result[c*WIDTH +: WIDTH] = WIDTH'(acc_next[c]);
            end
        end
    end

    // Window FSM: count accepted samples, latch config on the first, stage the result on the last
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            win_mode <= '0;
            win_n    <= '0;
            res_pend <= 1'b0;
            res_data <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
        end else begin
            res_pend <= window_done;
            if (window_done) begin
                res_data <= result;
            end
            if (in_valid) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    acc[c] <= acc_next[c];
                end
                if (first) begin
                    win_mode <= mode;
                    win_n    <= dec_clamped;
                end
                if (window_done) begin
                    count <= '0;
                    state <= IDLE;
                end else begin
                    count <= count_inc;
                    state <= ACCUM;
                end
            end
        end
    end

    // Output register: load new results, drop valid on handshake, flag overwrites of unread data
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else if (res_pend) begin
            out_data  <= res_data;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decimating_sample_sync.sv
// tb_decimating_sample_sync
// Directed, table-driven bench for decimating_sample_sync with hand-written
// sequences for overrun, mid-window reset, mid-window mode change and clamping.
module tb_decimating_sample_sync;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [23:0] in_data;
    logic [1:0]  mode;
    logic [2:0]  dec_log2;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic        iv;
        logic [23:0] d;
        logic [1:0]  md;
        logic [2:0]  n;
        logic        rdy;
        logic        ev;
        logic [23:0] ed;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    decimating_sample_sync dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .dec_log2  (dec_log2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overrun   (overrun)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] pk(input logic [11:0] c1, input logic [11:0] c0);
        return {c1, c0};
    endfunction

    function automatic vec_t mk(input string name, input logic rst, input logic iv,
                                input logic [23:0] d, input logic [1:0] md, input logic [2:0] n,
                                input logic rdy, input logic ev, input logic [23:0] ed,
                                input logic eo);
        vec_t v;
        v.name = name; v.rst = rst; v.iv = iv; v.d = d; v.md = md; v.n = n;
        v.rdy = rdy; v.ev = ev; v.ed = ed; v.eo = eo;
        return v;
    endfunction

    // Drive one cycle of inputs, then step past the rising edge
    task automatic applyStimulus(input logic rst, input logic iv, input logic [23:0] d,
                                 input logic [1:0] md, input logic [2:0] n, input logic rdy);
        reset     = rst;
        in_valid  = iv;
        in_data   = d;
        mode      = md;
        dec_log2  = n;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Compare the registered outputs against the expected values
    task automatic checkOutput(input string name, input logic ev, input logic [23:0] ed,
                               input logic eo);
        checks++;
        if (out_valid !== ev) begin
            errors++;
            $display("[TB] FAIL %s out_valid got %0b expected %0b", name, out_valid, ev);
        end
        checks++;
        if (out_data !== ed) begin
            errors++;
            $display("[TB] FAIL %s out_data got %h expected %h", name, out_data, ed);
        end
        checks++;
        if (overrun !== eo) begin
            errors++;
            $display("[TB] FAIL %s overrun got %0b expected %0b", name, overrun, eo);
        end
    endtask

    initial begin
        // Reset, then scenarios 1-3 as a per-cycle table
        vecs.push_back(mk("reset0",   1, 0, pk(0, 0),       0, 0, 1, 0, pk(0, 0), 0));
        vecs.push_back(mk("reset1",   1, 1, pk(7, 7),       1, 2, 1, 0, pk(0, 0), 0));
        // Mean, n=2, ch0 10,20,30,41
        vecs.push_back(mk("mean_s1",  0, 1, pk(0, 10),      1, 2, 1, 0, pk(0, 0), 0));
        vecs.push_back(mk("mean_s2",  0, 1, pk(0, 20),      1, 2, 1, 0, pk(0, 0), 0));
        vecs.push_back(mk("mean_s3",  0, 1, pk(0, 30),      1, 2, 1, 0, pk(0, 0), 0));
        vecs.push_back(mk("mean_s4",  0, 1, pk(0, 41),      1, 2, 1, 0, pk(0, 0), 0));
        vecs.push_back(mk("mean_out", 0, 0, pk(0, 0),       1, 2, 1, 1, pk(0, 25), 0));
        vecs.push_back(mk("mean_ack", 0, 0, pk(0, 0),       1, 2, 1, 0, pk(0, 25), 0));
        // Max, n=2, with gaps
        vecs.push_back(mk("max_s1",   0, 1, pk(12'h123, 5), 2, 2, 1, 0, pk(0, 25), 0));
        vecs.push_back(mk("max_gap1", 0, 0, pk(0, 0),       2, 2, 1, 0, pk(0, 25), 0));
        vecs.push_back(mk("max_s2",   0, 1, pk(12'hEFF, 3), 2, 2, 1, 0, pk(0, 25), 0));
        vecs.push_back(mk("max_gap2", 0, 0, pk(0, 0),       2, 2, 1, 0, pk(0, 25), 0));
        vecs.push_back(mk("max_s3",   0, 1, pk(12'hAAA, 9), 2, 2, 1, 0, pk(0, 25), 0));
        vecs.push_back(mk("max_s4",   0, 1, pk(12'hEAE, 1), 2, 2, 1, 0, pk(0, 25), 0));
        vecs.push_back(mk("max_out",  0, 0, pk(0, 0),       2, 2, 1, 1, pk(12'hEFF, 9), 0));
        vecs.push_back(mk("max_ack",  0, 0, pk(0, 0),       2, 2, 1, 0, pk(12'hEFF, 9), 0));
        // Min, n=2, with a gap
        vecs.push_back(mk("min_s1",   0, 1, pk(12'h123, 5), 3, 2, 1, 0, pk(12'hEFF, 9), 0));
        vecs.push_back(mk("min_s2",   0, 1, pk(12'hEFF, 3), 3, 2, 1, 0, pk(12'hEFF, 9), 0));
        vecs.push_back(mk("min_gap",  0, 0, pk(0, 0),       3, 2, 1, 0, pk(12'hEFF, 9), 0));
        vecs.push_back(mk("min_s3",   0, 1, pk(12'hAAA, 9), 3, 2, 1, 0, pk(12'hEFF, 9), 0));
        vecs.push_back(mk("min_s4",   0, 1, pk(12'hEAE, 1), 3, 2, 1, 0, pk(12'hEFF, 9), 0));
        vecs.push_back(mk("min_out",  0, 0, pk(0, 0),       3, 2, 1, 1, pk(12'h123, 1), 0));
        vecs.push_back(mk("min_ack",  0, 0, pk(0, 0),       3, 2, 1, 0, pk(12'h123, 1), 0));
        // Last, n=0 pass-through
        vecs.push_back(mk("pass_s1",  0, 1, pk(1, 12'hEFF), 0, 0, 1, 0, pk(12'h123, 1), 0));
        vecs.push_back(mk("pass_s2",  0, 1, pk(2, 12'hEAE), 0, 0, 1, 1, pk(1, 12'hEFF), 0));
        vecs.push_back(mk("pass_s3",  0, 1, pk(3, 12'hAAA), 0, 0, 1, 1, pk(2, 12'hEAE), 0));
        vecs.push_back(mk("pass_o3",  0, 0, pk(0, 0),       0, 0, 1, 1, pk(3, 12'hAAA), 0));
        vecs.push_back(mk("pass_ack", 0, 0, pk(0, 0),       0, 0, 1, 0, pk(3, 12'hAAA), 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].md, vecs[i].n, vecs[i].rdy);
            checkOutput(vecs[i].name, vecs[i].ev, vecs[i].ed, vecs[i].eo);
        end

        // Overrun: n=1, last mode, consumer stalled across two windows
        applyStimulus(0, 1, pk(0, 12'h111), 0, 1, 0); checkOutput("ovr_w1s1", 0, pk(3, 12'hAAA), 0);
        applyStimulus(0, 1, pk(0, 12'h222), 0, 1, 0); checkOutput("ovr_w1s2", 0, pk(3, 12'hAAA), 0);
        applyStimulus(0, 1, pk(0, 12'h333), 0, 1, 0); checkOutput("ovr_w1out", 1, pk(0, 12'h222), 0);
        applyStimulus(0, 1, pk(0, 12'h444), 0, 1, 0); checkOutput("ovr_hold", 1, pk(0, 12'h222), 0);
        applyStimulus(0, 0, pk(0, 0),       0, 1, 0); checkOutput("ovr_write", 1, pk(0, 12'h444), 1);
        applyStimulus(0, 0, pk(0, 0),       0, 1, 0); checkOutput("ovr_stable", 1, pk(0, 12'h444), 1);
        applyStimulus(0, 0, pk(0, 0),       0, 1, 1); checkOutput("ovr_ack", 0, pk(0, 12'h444), 1);

        // Reset after 3 of 4 samples discards the partial window
        applyStimulus(0, 1, pk(0, 100), 1, 2, 1); checkOutput("rst_p1", 0, pk(0, 12'h444), 1);
        applyStimulus(0, 1, pk(0, 200), 1, 2, 1); checkOutput("rst_p2", 0, pk(0, 12'h444), 1);
        applyStimulus(0, 1, pk(0, 300), 1, 2, 1); checkOutput("rst_p3", 0, pk(0, 12'h444), 1);
        applyStimulus(1, 1, pk(0, 999), 1, 2, 1); checkOutput("rst_clear", 0, pk(0, 0), 0);
        applyStimulus(0, 1, pk(8, 4),   1, 2, 1); checkOutput("rst_f1", 0, pk(0, 0), 0);
        applyStimulus(0, 1, pk(8, 8),   1, 2, 1); checkOutput("rst_f2", 0, pk(0, 0), 0);
        applyStimulus(0, 1, pk(8, 12),  1, 2, 1); checkOutput("rst_f3", 0, pk(0, 0), 0);
        applyStimulus(0, 1, pk(8, 16),  1, 2, 1); checkOutput("rst_f4", 0, pk(0, 0), 0);
        applyStimulus(0, 0, pk(0, 0),   1, 2, 1); checkOutput("rst_out", 1, pk(8, 10), 0);
        applyStimulus(0, 0, pk(0, 0),   1, 2, 1); checkOutput("rst_ack", 0, pk(8, 10), 0);

        // Mode change mid-window: this window stays mean, next window is max
        applyStimulus(0, 1, pk(0, 1),  1, 2, 1); checkOutput("chg_s1", 0, pk(8, 10), 0);
        applyStimulus(0, 1, pk(0, 2),  1, 2, 1); checkOutput("chg_s2", 0, pk(8, 10), 0);
        applyStimulus(0, 1, pk(0, 3),  2, 2, 1); checkOutput("chg_s3", 0, pk(8, 10), 0);
        applyStimulus(0, 1, pk(0, 10), 2, 2, 1); checkOutput("chg_s4", 0, pk(8, 10), 0);
        applyStimulus(0, 1, pk(0, 5),  2, 2, 1); checkOutput("chg_mean", 1, pk(0, 4), 0);
        applyStimulus(0, 1, pk(0, 50), 2, 2, 1); checkOutput("chg_m2", 0, pk(0, 4), 0);
        applyStimulus(0, 1, pk(0, 7),  2, 2, 1); checkOutput("chg_m3", 0, pk(0, 4), 0);
        applyStimulus(0, 1, pk(0, 6),  2, 2, 1); checkOutput("chg_m4", 0, pk(0, 4), 0);
        applyStimulus(0, 0, pk(0, 0),  2, 2, 1); checkOutput("chg_max", 1, pk(0, 50), 0);
        applyStimulus(0, 0, pk(0, 0),  2, 2, 1); checkOutput("chg_ack", 0, pk(0, 50), 0);

        // dec_log2=5 clamps to a 16-sample window; mean of 100..115 and of all-ones
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, pk(12'hFFF, 12'(100 + i)), 1, 5, 1);
            checkOutput($sformatf("clamp_s%0d", i), 0, pk(0, 50), 0);
        end
        applyStimulus(0, 0, pk(0, 0), 1, 5, 1); checkOutput("clamp_out", 1, pk(12'hFFF, 107), 0);
        applyStimulus(0, 0, pk(0, 0), 1, 5, 1); checkOutput("clamp_ack", 0, pk(12'hFFF, 107), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
